// File: rtl/memory_access_pipeline.sv
// Memory-access stage: 2^DEPTH_LOG2-word synchronous data memory between the EX/MA and MA/RW registers.
// Optional macro MA_ALIGN_CHECK_EN: misaligned ld/st skip the memory, complete in one cycle and set a sticky misalign flag.
module memory_access_pipeline #(
    parameter int unsigned DEPTH_LOG2 = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] pc,
    input  logic [31:0] aluResult,
    input  logic [31:0] op2,
    input  logic [31:0] instruction,
    input  logic [31:0] control,
    output logic        stall,
    output logic        out_valid,
    output logic [31:0] pc_out,
    output logic [31:0] aluResult_out,
    output logic [31:0] ldResult_out,
    output logic [31:0] instruction_out,
    output logic [31:0] control_out,
    output logic        misalign
);
    localparam int unsigned W     = 32;
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic {
        IDLE    = 1'b0,
        LD_WAIT = 1'b1
    } state_e;

    state_e state_q, state_d;

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] rdata_q;

    logic         out_valid_q, out_valid_d;
    logic [W-1:0] pc_q, pc_d;
    logic [W-1:0] alu_q, alu_d;
    logic [W-1:0] ldr_q, ldr_d;
    logic [W-1:0] instr_q, instr_d;
    logic [W-1:0] ctrl_q, ctrl_d;
    logic         misalign_q, misalign_d;

    // Fields of an in-flight load, parked while the read completes
    logic [W-1:0] hpc_q, hpc_d;
    logic [W-1:0] halu_q, halu_d;
    logic [W-1:0] hinstr_q, hinstr_d;
    logic [W-1:0] hctrl_q, hctrl_d;

    logic [DEPTH_LOG2-1:0] idx_c;
    logic                  is_st_c;
    logic                  is_ld_c;
    logic                  misaligned_c;
    logic                  wr_en_c;
    logic                  rd_en_c;
    logic                  stall_c;
    logic                  unused_addr_bits;

    assign idx_c   = aluResult[DEPTH_LOG2+1:2];
    assign is_st_c = control[0];
    assign is_ld_c = control[1];

`ifdef MA_ALIGN_CHECK_EN
    assign misaligned_c = (is_st_c || is_ld_c) && (aluResult[1:0] != 2'b00);
`else
    assign misaligned_c = 1'b0;
`endif

    // Address bits above the index wrap; the low two bits only matter for the alignment check
    assign unused_addr_bits = ^{aluResult[W-1:DEPTH_LOG2+2], aluResult[1:0]};

    always_comb begin
        state_d     = state_q;
        out_valid_d = 1'b0;
        pc_d        = pc_q;
        alu_d       = alu_q;
        ldr_d       = ldr_q;
        instr_d     = instr_q;
        ctrl_d      = ctrl_q;
        misalign_d  = misalign_q;
        hpc_d       = hpc_q;
        halu_d      = halu_q;
        hinstr_d    = hinstr_q;
        hctrl_d     = hctrl_q;
        wr_en_c     = 1'b0;
        rd_en_c     = 1'b0;
        stall_c     = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid && !rst) begin
                    if (is_ld_c && !misaligned_c) begin
                        stall_c  = 1'b1;
                        rd_en_c  = 1'b1;
                        hpc_d    = pc;
                        halu_d   = aluResult;
                        hinstr_d = instruction;
                        hctrl_d  = control;
                        state_d  = LD_WAIT;
                    end else begin
                        // A set isLd always wins over isSt, so a combined ld+st never writes
                        wr_en_c     = is_st_c && !is_ld_c && !misaligned_c;
                        out_valid_d = 1'b1;
                        pc_d        = pc;
                        alu_d       = aluResult;
                        ldr_d       = '0;
                        instr_d     = instruction;
                        ctrl_d      = control;
                        misalign_d  = misalign_q | misaligned_c;
                    end
                end
            end
            LD_WAIT: begin
                out_valid_d = 1'b1;
                pc_d        = hpc_q;
                alu_d       = halu_q;
                ldr_d       = rdata_q;
                instr_d     = hinstr_q;
                ctrl_d      = hctrl_q;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            pc_q        <= '0;
            alu_q       <= '0;
            ldr_q       <= '0;
            instr_q     <= '0;
            ctrl_q      <= '0;
            misalign_q  <= 1'b0;
            hpc_q       <= '0;
            halu_q      <= '0;
            hinstr_q    <= '0;
            hctrl_q     <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            pc_q        <= pc_d;
            alu_q       <= alu_d;
            ldr_q       <= ldr_d;
            instr_q     <= instr_d;
            ctrl_q      <= ctrl_d;
            misalign_q  <= misalign_d;
            hpc_q       <= hpc_d;
            halu_q      <= halu_d;
            hinstr_q    <= hinstr_d;
            hctrl_q     <= hctrl_d;
        end
    end

    // Data memory has no reset; contents survive rst
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem_q[idx_c] <= op2;
        end
        if (rd_en_c) begin
            rdata_q <= mem_q[idx_c];
        end
    end

    assign stall           = stall_c;
    assign out_valid       = out_valid_q;
    assign pc_out          = pc_q;
    assign aluResult_out   = alu_q;
    assign ldResult_out    = ldr_q;
    assign instruction_out = instr_q;
    assign control_out     = ctrl_q;
    assign misalign        = misalign_q;

endmodule

// File: tb/tb_memory_access_pipeline.sv
// Self-checking bench for memory_access_pipeline: reference memory model plus a scoreboard of expected MA/RW results.
module tb_memory_access_pipeline;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] pc;
    logic [31:0] aluResult;
    logic [31:0] op2;
    logic [31:0] instruction;
    logic [31:0] control;
    logic        stall;
    logic        out_valid;
    logic [31:0] pc_out;
    logic [31:0] aluResult_out;
    logic [31:0] ldResult_out;
    logic [31:0] instruction_out;
    logic [31:0] control_out;
    logic        misalign;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] ldr;
        logic [31:0] instr;
        logic [31:0] ctrl;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    logic [31:0] mem_m [256];
    logic [31:0] last_pc;
    int          checks;
    int          failures;

    memory_access_pipeline #(.DEPTH_LOG2(8)) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .pc              (pc),
        .aluResult       (aluResult),
        .op2             (op2),
        .instruction     (instruction),
        .control         (control),
        .stall           (stall),
        .out_valid       (out_valid),
        .pc_out          (pc_out),
        .aluResult_out   (aluResult_out),
        .ldResult_out    (ldResult_out),
        .instruction_out (instruction_out),
        .control_out     (control_out),
        .misalign        (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Every valid MA/RW result must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (sb_q.size() == 0) begin
                check_eq("unexpected_out", 32'(sb_q.size()), 32'd1);
            end else begin
                mon_e = sb_q.pop_front();
                check_eq("pc_out",          pc_out,          mon_e.pc);
                check_eq("aluResult_out",   aluResult_out,   mon_e.alu);
                check_eq("ldResult_out",    ldResult_out,    mon_e.ldr);
                check_eq("instruction_out", instruction_out, mon_e.instr);
                check_eq("control_out",     control_out,     mon_e.ctrl);
                last_pc = mon_e.pc;
            end
        end
    end

    task automatic send(input logic [31:0] p, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] ins, input logic [31:0] c);
        logic       is_st;
        logic       is_ld;
        logic       mis;
        logic       eff_ld;
        logic [7:0] idx;
        exp_t       e;
        is_st = c[0];
        is_ld = c[1];
`ifdef MA_ALIGN_CHECK_EN
        mis = (is_st || is_ld) && (a[1:0] != 2'b00);
`else
        mis = 1'b0;
`endif
        idx    = a[9:2];
        eff_ld = is_ld && !mis;
        e = '{p, a, (eff_ld ? mem_m[idx] : 32'h0), ins, c};
        if (is_st && !is_ld && !mis) mem_m[idx] = d;
        @(negedge clk);
        in_valid    = 1'b1;
        pc          = p;
        aluResult   = a;
        op2         = d;
        instruction = ins;
        control     = c;
        #1;
        check_eq("stall", 32'(stall), 32'(eff_ld));
        sb_q.push_back(e);
        if (eff_ld) begin
            @(negedge clk);
            #1;
            check_eq("ld_bubble", 32'(out_valid), 32'd0);
            check_eq("stall_ld_wait", 32'(stall), 32'd0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check_eq({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check_eq({tag, "_pc_out"}, pc_out, 32'd0);
        check_eq({tag, "_alu_out"}, aluResult_out, 32'd0);
        check_eq({tag, "_ldr_out"}, ldResult_out, 32'd0);
        check_eq({tag, "_instr_out"}, instruction_out, 32'd0);
        check_eq({tag, "_ctrl_out"}, control_out, 32'd0);
        check_eq({tag, "_misalign"}, 32'(misalign), 32'd0);
        check_eq({tag, "_stall"}, 32'(stall), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] r;
        logic [31:0] a;
        int          kind;
        checks      = 0;
        failures    = 0;
        last_pc     = 32'h0;
        rst         = 1'b0;
        in_valid    = 1'b0;
        pc          = 32'h0;
        aluResult   = 32'h0;
        op2         = 32'h0;
        instruction = 32'h0;
        control     = 32'h0;
        #1 rst = 1'b1;
        #2 check_zero_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Non-memory pass-through
        send(32'h18, 32'h0, 32'h0, 32'h33333333, 32'h40);
        // Store then load same index
        send(32'h1C, 32'h10, 32'hDEADBEEF, 32'h00A12023, 32'h1);
        send(32'h20, 32'h10, 32'h0, 32'h00012083, 32'h2);
        // Index wrap: 0x400 and 0x000 share word 0
        send(32'h24, 32'h400, 32'h12345678, 32'h00B02023, 32'h1);
        send(32'h28, 32'h000, 32'h0, 32'h00002103, 32'h2);
        // ld+st together behaves as a load with no write
        send(32'h2C, 32'h10, 32'h55555555, 32'h0, 32'h3);
        send(32'h30, 32'h10, 32'h0, 32'h0, 32'h2);

        // Idle: out_valid drops, data outputs hold
        idle(3);
        #1;
        check_eq("idle_out_valid", 32'(out_valid), 32'd0);
        check_eq("hold_pc", pc_out, last_pc);

        // Fill a working set, then a random mix over it (upper address bits vary to exercise wrap)
        for (int i = 0; i < 16; i++) begin
            r = $urandom();
            send(32'h100 + 32'(i * 4), 32'h200 + 32'(i * 4), r, 32'h1000 + 32'(i), 32'h1);
        end
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 3);
            r    = $urandom();
            a    = 32'h200 + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3) << 10);
            case (kind)
                0:       send(32'h400 + 32'(i * 4), r, 32'h0, r ^ 32'hA5A5A5A5, {r[31:2], 2'b00});
                1:       send(32'h400 + 32'(i * 4), a, r, 32'h2000 + 32'(i), {r[31:2], 2'b01});
                2:       send(32'h400 + 32'(i * 4), a, r, 32'h3000 + 32'(i), {r[31:2], 2'b10});
                default: send(32'h400 + 32'(i * 4), a, r, 32'h4000 + 32'(i), {r[31:2], 2'b11});
            endcase
            if ((i % 9) == 8) idle(1);
        end

        // Reset while a load waits: outputs clear at once, no result afterwards
        send(32'h88, 32'h10, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        in_valid    = 1'b1;
        pc          = 32'h8C;
        aluResult   = 32'h10;
        control     = 32'h2;
        instruction = 32'h77;
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_zero_outputs("rst_mid_ld");
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        idle(4);

        // Misalignment: store at 0x11 hits word 4 only without the check enabled
        send(32'h90, 32'h10, 32'h11112222, 32'h0, 32'h1);
        send(32'h94, 32'h11, 32'hCAFEF00D, 32'h0, 32'h1);
        send(32'h98, 32'h10, 32'h0, 32'h0, 32'h2);
        send(32'h9C, 32'h13, 32'h0, 32'h0, 32'h2);
        idle(3);
        #1;
`ifdef MA_ALIGN_CHECK_EN
        check_eq("misalign_set", 32'(misalign), 32'd1);
`else
        check_eq("misalign_set", 32'(misalign), 32'd0);
`endif
        send(32'hA0, 32'h14, 32'h0, 32'h0, 32'h40);
        idle(3);
        #1;
`ifdef MA_ALIGN_CHECK_EN
        check_eq("misalign_sticky", 32'(misalign), 32'd1);
`else
        check_eq("misalign_sticky", 32'(misalign), 32'd0);
`endif

        check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/memory_access_pipeline.md
MEMORY_ACCESS_PIPELINE -- requirements
Module: memory_access_pipeline

Interface
REQ-001 Parameter DEPTH_LOG2, default 8: the data memory holds 2^DEPTH_LOG2 32-bit words.
REQ-002 clk  input  1  Single clock; all state updates on the rising edge.
REQ-003 rst  input  1  Asynchronous, active-high reset.
REQ-004 in_valid  input  1  The EX/MA register holds a live instruction.
REQ-005 pc  input  32  PC from the EX stage.
REQ-006 aluResult  input  32  ALU result from the EX stage; it is the effective address for ld/st.
REQ-007 op2  input  32  Store data from the EX stage.
REQ-008 instruction  input  32  Instruction word from the EX stage.
REQ-009 control  input  32  Control word from the EX stage; bit 0 = isSt, bit 1 = isLd, other bits are pass-through.
REQ-010 stall  output  1  Combinational hold request to the EX stage.
REQ-011 out_valid  output  1  The MA/RW register holds a live instruction.
REQ-012 pc_out, aluResult_out, ldResult_out, instruction_out, control_out  output  32 each  MA/RW register fields.
REQ-013 misalign  output  1  Sticky misaligned-access flag (present only per REQ-031).

Function
REQ-014 State machine states: IDLE and LD_WAIT; the reset state is IDLE.
REQ-015 stall SHALL equal (state==IDLE && in_valid && isLd) and SHALL be 0 in every other case.
REQ-016 Word index SHALL be aluResult[DEPTH_LOG2+1:2]; higher address bits are ignored (the index wraps).
REQ-017 IDLE, in_valid, not isLd: on the next edge, register all fields, set ldResult_out=0 and out_valid=1; latency is 1 cycle.
REQ-018 IDLE, in_valid, isSt: mem[index] <= op2 on the same edge; a store writes exactly one word.
REQ-019 IDLE, in_valid, isLd: on the edge, latch pc/aluResult/instruction/control and issue a synchronous read; state goes to LD_WAIT and out_valid goes to 0 (bubble).
REQ-020 LD_WAIT: inputs are ignored (EX still holds the same ld); on the edge, ldResult_out <= read data, the latched fields go to the outputs, out_valid=1, and state returns to IDLE; ld latency is 2 cycles.
REQ-021 IDLE, in_valid=0: on the edge, out_valid <= 0 and the data outputs hold their previous values.
REQ-022 A store followed by a load to the same index on the next accepted instruction SHALL return the stored data.
REQ-023 isSt and isLd both set: treated as a load, and no write occurs.
REQ-024 The memory is not initialised by reset; reads of never-written words are undefined.

Reset
REQ-025 While rst is high, state goes to IDLE and out_valid, all *_out outputs and misalign go to 0 immediately, independent of clk.
REQ-026 Reset asserted in LD_WAIT abandons the pending load, and no output is produced for it.
REQ-027 stall SHALL be 0 while rst is high.
REQ-028 The first edge after rst falls is processed normally from IDLE.

Configuration
REQ-029 Macro MA_ALIGN_CHECK_EN.
REQ-030 Without the macro: aluResult[1:0] is ignored, and misalign is tied to 0.
REQ-031 With the macro, for ld/st with aluResult[1:0]!=0:
- no memory write and no read;
- the instruction completes in 1 cycle with ldResult_out=0;
- no stall is raised;
- misalign is set to 1 and stays set until reset.

Verification
REQ-032 Non-memory pass-through: pc=0x18, aluResult=0x00000000, instruction=0x33333333, control=0x40 -> next edge pc_out=0x18, control_out=0x40, ldResult_out=0, out_valid=1, stall=0.
REQ-033 Store then load: st op2=0xDEADBEEF at aluResult=0x10, then ld at 0x10 -> the ld cycle has stall=1, the following edge has out_valid=0, and the edge after has ldResult_out=0xDEADBEEF, out_valid=1.
REQ-034 Address wrap with DEPTH_LOG2=8: st 0x12345678 at 0x400, then ld at 0x000 -> ldResult_out=0x12345678.
REQ-035 Reset mid-load: assert rst during LD_WAIT -> outputs are 0 at once, state is IDLE, and no load result appears after release.
REQ-036 Misaligned store at 0x11 with MA_ALIGN_CHECK_EN -> mem[4] is unchanged, misalign=1 persists, stall=0; without the macro, mem[4] receives the data.
